bias_mem_loader: RTL and testbench
==================================

// Module: bias_mem_loader
// PURPOSE
//  Write-side master for the local bias memory.
//  Accepts packed 32-bit words from the input stream (valid/ready), each carrying two 16-bit biases.
//  Unpacks them and drives write_bias_addr/data/signal into the bias memory, one bias per cycle, from address 0 upward.
//  Sits between the layer-load controller / DMA stream and the bias memory; signals done when all biases are written.
// PARAMETERS
//  MAX_BIAS_NUM  10  capacity of the bias memory; legal bias_num range is 1..MAX_BIAS_NUM
//  DATA_W        16  bias width; write_bias_data width
//  BUS_W         32  input word width; must equal 2*DATA_W
// PORTS
//  clk               in   1       clock, rising edge
//  rst               in   1       reset, asynchronous, active-high
//  start             in   1       1-cycle pulse; begins a load of bias_num biases
//  bias_num          in   16      number of biases to load; sampled on the accepted start
//  abort             in   1       cancel the load in progress
//  in_valid          in   1       input word valid
//  in_data           in   BUS_W   [15:0] = lower-address bias, [31:16] = next-address bias
//  in_ready          out  1       loader can accept a word this cycle
//  write_bias_addr   out  16      bias memory write address
//  write_bias_data   out  DATA_W  bias memory write data
//  write_bias_signal out  1       bias memory write enable, 1 cycle per bias
//  busy              out  1       load in progress (any state other than IDLE)
//  done              out  1       1-cycle pulse after the last write
//  err               out  1       1-cycle pulse when start is rejected
// BEHAVIOUR
//  Reset: all outputs 0. State = IDLE. Counter, word buffer and latched count all 0.
//  FSM states:
//   IDLE: if start && 1<=bias_num<=MAX_BIAS_NUM, latch num=bias_num, cnt=0, go to ACCEPT.
//         If start && bias_num is out of range, pulse err next cycle, stay in IDLE, no writes.
//   ACCEPT: in_ready=1. On in_valid&&in_ready, capture in_data into buf and go to WR_LO.
//           in_valid low: hold in ACCEPT indefinitely.
//   WR_LO: write_bias_signal=1, addr=cnt, data=buf[15:0]; cnt++.
//          If cnt+1==num go to DONE, else go to WR_HI.
//   WR_HI: write_bias_signal=1, addr=cnt, data=buf[31:16]; cnt++.
//          If cnt+1==num go to DONE, else go to ACCEPT.
//   DONE: done=1 for exactly 1 cycle, then IDLE.
//  Output timing:
//   - in_ready, write_* and done are decoded from registered state/cnt/buf only; no in->out comb path.
//   - write_bias_addr and write_bias_data are 0 whenever write_bias_signal=0.
//  Throughput and latency:
//   - 2 biases per 3 cycles when in_valid is held high.
//   - First write occurs 1 cycle after the accepting handshake.
//  Odd bias_num: the upper half of the last word is discarded. Exactly num words are not required:
//   ceil(num/2) words are consumed, and no further word is accepted.
//  start while busy is ignored: no err, and num is not re-latched.
//  abort (priority over every other event) in any non-IDLE state:
//   - Next cycle: IDLE, in_ready=0, no write, no done.
//   - Biases already written stay in memory.
//   - abort together with start while in IDLE: start wins.
//  Simultaneous events: the handshake cycle in ACCEPT never issues a write; writes occur only in WR_LO/WR_HI.
//  Reset mid-load: immediate return to IDLE, all outputs 0. Bias memory contents are owned by the memory (not cleared here).
//  Address never exceeds num-1 <= MAX_BIAS_NUM-1; cnt is 16-bit with no wrap.
// TESTING
//  T1 start, num=4, words 0x0002_0001, 0x0004_0003 back-to-back -> writes (0,1)(1,2)(2,3)(3,4) on consecutive WR cycles; done 1 cycle after last write; busy falls with done.
//  T2 num=3, words 0xBBBB_AAAA, 0xDEAD_CCCC -> writes (0,AAAA)(1,BBBB)(2,CCCC); 0xDEAD never written; in_ready=0 after the 2nd word.
//  T3 num=10 with in_valid toggled randomly -> 10 writes, addr 0..9 in order, no write during stalls, 5 handshakes total.
//  T4 start with num=0, then num=11 -> err pulse each time; busy, in_ready and write_bias_signal stay 0.
//  T5 start mid-load of num=6 with num=2 -> ignored; 6 writes complete. Separately, abort after the 3rd write -> IDLE next cycle, no done, no further writes.
//  T6 assert rst during WR_HI -> all outputs 0 asynchronously; a fresh start, num=2 after release loads correctly.

Source files
------------

// File: rtl/bias_mem_loader.sv
// Write-side master for the local bias memory: unpacks 32-bit stream words into
// two 16-bit biases and writes them one per cycle from address 0 upward.
module bias_mem_loader #(
    parameter int MAX_BIAS_NUM = 10,
    parameter int DATA_W       = 16,
    parameter int BUS_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       bias_num,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [BUS_W-1:0]  in_data,
    output logic              in_ready,
    output logic [15:0]       write_bias_addr,
    output logic [DATA_W-1:0] write_bias_data,
    output logic              write_bias_signal,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // state    | meaning
    // S_IDLE   | waiting for start
    // S_ACCEPT | in_ready high, waiting for a stream word
    // S_WR_LO  | writing low half of the buffered word
    // S_WR_HI  | writing high half of the buffered word
    // S_DONE   | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       num_q, num_d;
    logic [BUS_W-1:0]  word_q, word_d;
    logic              err_d;
    logic [15:0]       cnt_inc;
    logic              num_ok;

    assign cnt_inc = cnt_q + 16'd1;
    assign num_ok  = (bias_num >= 16'd1) && (bias_num <= 16'(MAX_BIAS_NUM));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            word_q  <= '0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            word_q  <= word_d;
            err     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        word_d  = word_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_ok) begin
                        num_d   = bias_num;
                        cnt_d   = '0;
                        state_d = S_ACCEPT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ACCEPT: begin
                if (in_valid) begin
                    word_d  = in_data;
                    state_d = S_WR_LO;
                end
            end
            S_WR_LO: begin
                cnt_d   = cnt_inc;
                state_d = (cnt_inc == num_q) ? S_DONE : S_WR_HI;
            end
            S_WR_HI: begin
                cnt_d   = cnt_inc;
                state_d = (cnt_inc == num_q) ? S_DONE : S_ACCEPT;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort overrides everything once a load is under way; in IDLE start wins.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    // All outputs decode registered state only, so no input reaches an output combinationally.
    assign in_ready          = (state_q == S_ACCEPT);
    assign write_bias_signal = (state_q == S_WR_LO) || (state_q == S_WR_HI);
    assign write_bias_addr   = write_bias_signal ? cnt_q : 16'd0;
    assign write_bias_data   = (state_q == S_WR_LO) ? word_q[DATA_W-1:0] :
                               (state_q == S_WR_HI) ? word_q[BUS_W-1:DATA_W] :
                               {DATA_W{1'b0}};
    assign busy              = (state_q != S_IDLE);
    assign done              = (state_q == S_DONE);

endmodule

// File: tb/tb_bias_mem_loader.sv
// Scoreboard bench for bias_mem_loader: stimulus pushes expected writes, a forked
// monitor pops and compares every write and checks done/idle-zero behaviour.
module tb_bias_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] bias_num;
    logic        abort;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [15:0] write_bias_addr;
    logic [15:0] write_bias_data;
    logic        write_bias_signal;
    logic        busy;
    logic        done;
    logic        err;

    bias_mem_loader dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .bias_num          (bias_num),
        .abort             (abort),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_ready          (in_ready),
        .write_bias_addr   (write_bias_addr),
        .write_bias_data   (write_bias_data),
        .write_bias_signal (write_bias_signal),
        .busy              (busy),
        .done              (done),
        .err               (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        bit          last;
    } wr_t;

    wr_t         exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          hs_cnt = 0;
    int          err_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] words [0:4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        bit  prev_last = 0;
        bit  cur_last;
        wr_t e;
        forever begin
            @(negedge clk);
            if (in_valid && in_ready) hs_cnt++;
            if (err) err_cnt++;
            if (done) begin
                chk("done_after_last_write", 32'(prev_last), 32'd1);
                done_cnt++;
            end
            cur_last = 0;
            if (write_bias_signal) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr=%0d data=0x%0h expected none at %0t",
                             write_bias_addr, write_bias_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", 32'(write_bias_addr), 32'(e.addr));
                    chk("write_data", 32'(write_bias_data), 32'(e.data));
                    cur_last = e.last;
                end
            end else begin
                chk("idle_addr_data_zero", {write_bias_addr, write_bias_data}, 32'd0);
            end
            prev_last = cur_last;
        end
    endtask

    task automatic push_load(input int n);
        wr_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = 16'(i);
            e.data = (i % 2 == 1) ? words[i/2][31:16] : words[i/2][15:0];
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_start(input logic [15:0] n);
        start    = 1'b1;
        bias_num = n;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        bit ok = 0;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = w;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            in_valid = 1'b0;
            chk("handshake_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic wait_done(input string name);
        bit found = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) begin found = 1; break; end
        end
        chk({name, "_done_seen"}, 32'(found), 32'd1);
        if (found) begin
            chk({name, "_busy_at_done"}, 32'(busy), 32'd1);
            @(negedge clk);
            chk({name, "_busy_after_done"}, 32'(busy), 32'd0);
            chk({name, "_ready_after_done"}, 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int hs0, err0, done0;
        rst = 1'b1; start = 1'b0; bias_num = '0; abort = 1'b0;
        in_valid = 1'b0; in_data = '0;
        #12;
        chk("reset_outputs",
            {24'd0, in_ready, write_bias_signal, busy, done, err, 3'd0}, 32'd0);
        chk("reset_addr_data", {write_bias_addr, write_bias_data}, 32'd0);
        fork monitor(); join_none
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // T1: num=4, back-to-back words
        words[0] = 32'h0002_0001; words[1] = 32'h0004_0003;
        push_load(4);
        hs0 = hs_cnt;
        do_start(16'd4);
        send_word(words[0], 0);
        send_word(words[1], 0);
        wait_done("t1");
        chk("t1_handshakes", 32'(hs_cnt - hs0), 32'd2);
        chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // T2: odd count, upper half of last word discarded, no third word taken
        words[0] = 32'hBBBB_AAAA; words[1] = 32'hDEAD_CCCC;
        push_load(3);
        hs0 = hs_cnt;
        do_start(16'd3);
        send_word(words[0], 0);
        send_word(words[1], 0);
        chk("t2_ready_after_last_word", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_data = 32'h1111_2222;
        wait_done("t2");
        in_valid = 1'b0;
        chk("t2_handshakes", 32'(hs_cnt - hs0), 32'd2);
        chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // T3: num=10 with random stalls
        words[0] = 32'h1001_1000; words[1] = 32'h1003_1002; words[2] = 32'h1005_1004;
        words[3] = 32'h1007_1006; words[4] = 32'h1009_1008;
        push_load(10);
        hs0 = hs_cnt;
        do_start(16'd10);
        for (int i = 0; i < 5; i++) send_word(words[i], int'($urandom_range(0, 3)));
        wait_done("t3");
        chk("t3_handshakes", 32'(hs_cnt - hs0), 32'd5);
        chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // T4: out-of-range bias_num rejected
        err0 = err_cnt;
        do_start(16'd0);
        @(negedge clk);
        chk("t4_err_num0", 32'(err), 32'd1);
        chk("t4_busy_num0", {30'd0, busy, in_ready}, 32'd0);
        @(posedge clk); #1;
        do_start(16'd11);
        @(negedge clk);
        chk("t4_err_num11", 32'(err), 32'd1);
        chk("t4_busy_num11", {30'd0, busy, in_ready}, 32'd0);
        @(negedge clk);
        chk("t4_err_single_pulse", 32'(err), 32'd0);
        chk("t4_err_pulses", 32'(err_cnt - err0), 32'd2);
        @(posedge clk); #1;

        // T5a: start while busy is ignored
        words[0] = 32'h0B00_0A00; words[1] = 32'h0D00_0C00; words[2] = 32'h0F00_0E00;
        push_load(6);
        err0 = err_cnt;
        do_start(16'd6);
        send_word(words[0], 0);
        do_start(16'd2);
        send_word(words[1], 0);
        send_word(words[2], 0);
        wait_done("t5a");
        chk("t5a_no_err", 32'(err_cnt - err0), 32'd0);
        chk("t5a_queue_empty", 32'(exp_q.size()), 32'd0);

        // T5b: abort during the 3rd write
        words[0] = 32'h2222_1111; words[1] = 32'h4444_3333; words[2] = 32'h6666_5555;
        push_load(3);
        exp_q[2].last = 0;
        done0 = done_cnt;
        do_start(16'd6);
        send_word(words[0], 0);
        send_word(words[1], 0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("t5b_idle_after_abort", {29'd0, busy, in_ready, write_bias_signal}, 32'd0);
        repeat (6) begin @(posedge clk); #1; end
        chk("t5b_no_done", 32'(done_cnt - done0), 32'd0);
        chk("t5b_queue_empty", 32'(exp_q.size()), 32'd0);

        // T6: reset during WR_HI, then fresh load
        words[0] = 32'h7777_6666;
        push_load(1);
        exp_q[0].last = 0;
        do_start(16'd4);
        send_word(words[0], 0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t6_async_reset_outputs",
            {24'd0, in_ready, write_bias_signal, busy, done, err, 3'd0}, 32'd0);
        chk("t6_async_reset_addr_data", {write_bias_addr, write_bias_data}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t6_queue_after_reset", 32'(exp_q.size()), 32'd0);
        words[0] = 32'h5A5A_A5A5;
        push_load(2);
        do_start(16'd2);
        send_word(words[0], 0);
        wait_done("t6");
        chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
